aes_round_ctrl: RTL and testbench



---
 rtl/aes_ctrl_pkg.sv | 18 +
 rtl/aes_byte_cnt.sv | 40 ++++
 rtl/aes_round_ctrl.sv | 118 +++++++++++
 tb/tb_aes_round_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the byte-serial AES round sequencer.
package aes_ctrl_pkg;

  localparam int AES_NB     = 16;
  localparam int AES_NR_128 = 10;
  localparam int AES_KR_W   = 4;
  localparam int AES_BI_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KWAIT  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RKWAIT = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_byte_cnt.sv
// Modulo-NB byte position counter with clear, enable and terminal flag.
import aes_ctrl_pkg::*;

module aes_byte_cnt #(
  parameter int NB = AES_NB,
  parameter int W  = AES_BI_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  localparam logic [W-1:0] CNT_LAST = W'(NB - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the byte-serial AES encryption datapath: key fetch handshake,
// AddRoundKey select, byte stepping and result hand-off.
//
// state  | meaning
// IDLE   | waiting for start_valid
// KWAIT  | requesting round key 0
// LOAD   | initial AddRoundKey, one byte per cycle
// RKWAIT | requesting round key rnd
// ROUND  | round function result captured, one byte per cycle
// DONE   | ciphertext ready, held until res_ready
import aes_ctrl_pkg::*;

module aes_round_ctrl #(
  parameter int NR = AES_NR_128,
  parameter int NB = AES_NB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  output logic                key_req,
  output logic [AES_KR_W-1:0] key_round,
  input  logic                key_valid,
  output logic                ld_r,
  output logic                byte_en,
  output logic [AES_BI_W-1:0] byte_idx,
  output logic                last_rnd,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  localparam logic [AES_KR_W-1:0] RND_LAST = AES_KR_W'(NR);

  aes_ctrl_state_t       state_q, state_d;
  logic [AES_KR_W-1:0]   rnd_q, rnd_d;
  logic                  cnt_en;
  logic                  cnt_last;
  logic [AES_BI_W-1:0]   cnt;

  assign cnt_en = (state_q == ST_LOAD) || (state_q == ST_ROUND);

  aes_byte_cnt #(
    .NB (NB),
    .W  (AES_BI_W)
  ) u_byte_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!cnt_en),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_KWAIT;
          rnd_d   = '0;
        end
      end
      ST_KWAIT: begin
        if (key_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cnt_last) begin
          state_d = ST_RKWAIT;
          rnd_d   = AES_KR_W'(1);
        end
      end
      ST_RKWAIT: begin
        if (key_valid) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (cnt_last) begin
          if (rnd_q == RND_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RKWAIT;
            rnd_d   = rnd_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Outputs depend only on registered state so no input reaches an output.
  assign start_ready = (state_q == ST_IDLE);
  assign key_req     = (state_q == ST_KWAIT) || (state_q == ST_RKWAIT);
  assign key_round   = key_req ? rnd_q : '0;
  assign ld_r        = (state_q == ST_LOAD);
  assign byte_en     = cnt_en;
  assign byte_idx    = cnt;
  assign last_rnd    = (state_q == ST_ROUND) && (rnd_q == RND_LAST);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: table of block scenarios plus reset and abort sequences.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int NB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic       key_req;
  logic [3:0] key_round;
  logic       key_valid;
  logic       ld_r;
  logic       byte_en;
  logic [3:0] byte_idx;
  logic       last_rnd;
  logic       res_valid;
  logic       res_ready;
  logic       busy;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .NB(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_req     (key_req),
    .key_round   (key_round),
    .key_valid   (key_valid),
    .ld_r        (ld_r),
    .byte_en     (byte_en),
    .byte_idx    (byte_idx),
    .last_rnd    (last_rnd),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  typedef struct {
    int kw_dly;
    int rk_rnd;
    int rk_dly;
    bit noise;
    int rdy_hold;
    int exp_done;
    int exp_rv;
  } vec_t;

  vec_t vecs[6];

  // Runs one block starting at the negedge of an IDLE cycle (cycle 0 = start accepted).
  // Returns at the negedge of the IDLE cycle following DONE exit.
  task automatic run_block(input vec_t v, input string tag);
    int cyc = 0, wcnt = 0, hold = 0, hs = 0, dly;
    int o_done = -1, o_rv = 0, o_ld = 0, o_last = 0, o_en = 0;
    int o_idx_err = 0, o_wait_err = 0, o_last_err = 0, o_key_err = 0, o_sr_err = 0;
    bit fin = 1'b0;
    start_valid = 1'b1;
    while (!fin && cyc < 1000) begin
      if (res_valid && o_done < 0) o_done = cyc;
      if (res_valid) begin
        o_rv++;
        if (start_ready) o_sr_err++;
      end
      if (byte_en) begin
        if (int'(byte_idx) != (o_en % NB)) o_idx_err++;
        if (key_req) o_wait_err++;
        o_en++;
      end
      if (ld_r) o_ld++;
      if (last_rnd) begin
        o_last++;
        if (hs != NR + 1) o_last_err++;
      end
      if (key_req) begin
        dly = (key_round == 4'd0) ? v.kw_dly :
              ((int'(key_round) == v.rk_rnd) ? v.rk_dly : 0);
        key_valid = (wcnt >= dly);
        if (key_valid) begin
          if (int'(key_round) != hs) o_key_err++;
          hs++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        key_valid = v.noise ? (cyc % 2 == 1) : 1'b1;
      end
      if (!v.noise && cyc > 0)
        start_valid = (res_valid && hold < v.rdy_hold) ? (cyc % 2 == 1) : 1'b0;
      if (res_valid) begin
        if (hold < v.rdy_hold) begin
          res_ready = 1'b0;
          hold++;
        end else begin
          res_ready = 1'b1;
          fin = 1'b1;
        end
      end else begin
        res_ready = v.noise ? (cyc % 2 == 0) : 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s completes", tag), int'(fin), 1);
    check($sformatf("%s idle after exit", tag), int'(start_ready), 1);
    check($sformatf("%s busy after exit", tag), int'(busy), 0);
    check($sformatf("%s res_valid first cycle", tag), o_done, v.exp_done);
    check($sformatf("%s res_valid cycles", tag), o_rv, v.exp_rv);
    check($sformatf("%s start_ready in DONE", tag), o_sr_err, 0);
    check($sformatf("%s ld_r cycles", tag), o_ld, NB);
    check($sformatf("%s last_rnd cycles", tag), o_last, NB);
    check($sformatf("%s last_rnd outside final round", tag), o_last_err, 0);
    check($sformatf("%s byte_en cycles", tag), o_en, NB * (NR + 1));
    check($sformatf("%s byte_idx sequence errors", tag), o_idx_err, 0);
    check($sformatf("%s byte_en during key wait", tag), o_wait_err, 0);
    check($sformatf("%s key handshakes", tag), hs, NR + 1);
    check($sformatf("%s key_round order errors", tag), o_key_err, 0);
  endtask

  initial begin
    vecs[0] = '{kw_dly: 0, rk_rnd: 0,  rk_dly: 0, noise: 1'b0, rdy_hold: 0, exp_done: 188, exp_rv: 1};
    vecs[1] = '{kw_dly: 3, rk_rnd: 5,  rk_dly: 3, noise: 1'b0, rdy_hold: 0, exp_done: 194, exp_rv: 1};
    vecs[2] = '{kw_dly: 0, rk_rnd: 0,  rk_dly: 0, noise: 1'b0, rdy_hold: 5, exp_done: 188, exp_rv: 6};
    vecs[3] = '{kw_dly: 0, rk_rnd: 0,  rk_dly: 0, noise: 1'b1, rdy_hold: 0, exp_done: 188, exp_rv: 1};
    vecs[4] = '{kw_dly: 2, rk_rnd: 10, rk_dly: 1, noise: 1'b1, rdy_hold: 0, exp_done: 191, exp_rv: 1};
    vecs[5] = '{kw_dly: 0, rk_rnd: 0,  rk_dly: 0, noise: 1'b1, rdy_hold: 2, exp_done: 188, exp_rv: 3};

    rst         = 1'b1;
    start_valid = 1'b0;
    key_valid   = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset start_ready", int'(start_ready), 1);
    check("reset key_round",   int'(key_round),   0);
    check("reset byte_idx",    int'(byte_idx),    0);
    check("reset busy",        int'(busy),        0);
    check("reset key_req",     int'(key_req),     0);
    check("reset ld_r",        int'(ld_r),        0);
    check("reset byte_en",     int'(byte_en),     0);
    check("reset last_rnd",    int'(last_rnd),    0);
    check("reset res_valid",   int'(res_valid),   0);

    for (int i = 0; i < 6; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Abort in round 4 at byte 7 (cycle 77 with a zero-wait expander).
    start_valid = 1'b1;
    key_valid   = 1'b1;
    res_ready   = 1'b1;
    for (int c = 0; c < 77; c++) begin
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
    end
    check("abort point byte_idx", int'(byte_idx), 7);
    check("abort point ld_r",     int'(ld_r),     0);
    check("abort point byte_en",  int'(byte_en),  1);
    check("abort point last_rnd", int'(last_rnd), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",        int'(busy),        0);
    check("abort start_ready", int'(start_ready), 1);
    check("abort key_round",   int'(key_round),   0);
    check("abort byte_idx",    int'(byte_idx),    0);
    check("abort byte_en",     int'(byte_en),     0);
    run_block(vecs[0], "post-abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
